// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB camera configuration sequencer.
package sccb_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPowerupWait,
    StFetch,
    StDecode,
    StSend,
    StWaitAccept,
    StWaitDone,
    StDelay,
    StDone
  } seq_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;

  // Built-in OV7670-style bring-up table: soft reset, settle, RGB565 output.
  function automatic logic [15:0] default_entry(input logic [31:0] idx);
    logic [15:0] e;
    case (idx)
      32'd0:   e = 16'h1280;
      32'd1:   e = DELAY_MARKER;
      32'd2:   e = 16'h1204;
      32'd3:   e = 16'h1101;
      32'd4:   e = 16'h0C00;
      32'd5:   e = 16'h3E00;
      32'd6:   e = 16'h40D0;
      32'd7:   e = 16'h8C00;
      default: e = END_MARKER;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/camera_config_rom.sv
// Synchronous register-table ROM, one-cycle read latency.
// USE_INIT selects the ROM_INIT parameter table instead of the built-in one.
module camera_config_rom
  import sccb_pkg::*;
#(
  parameter int unsigned                 ROM_DEPTH = 128,
  parameter bit                          USE_INIT  = 1'b0,
  parameter logic [ROM_DEPTH-1:0][15:0]  ROM_INIT  = '1,
  localparam int unsigned                AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  output entry_t        o_entry
);

  // Registered read of the addressed entry.
  always_ff @(posedge i_clk) begin
    if (USE_INIT) begin
      o_entry <= entry_t'(ROM_INIT[i_addr]);
    end else begin
      o_entry <= entry_t'(default_entry(32'(i_addr)));
    end
  end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the camera register table and feeds each {addr, data} pair to the
// SCCB write transmitter, inserting millisecond delays where requested.
// Optional watchdog per write: define SCCB_SEQ_TIMEOUT_EN.
module sccb_config_sequencer
  import sccb_pkg::*;
#(
  parameter int unsigned                CLK_FREQUENCY  = 25000000,
  parameter int unsigned                DELAY_MS       = 10,
  parameter int unsigned                ROM_DEPTH      = 128,
  parameter int unsigned                TIMEOUT_CYCLES = 65535,
  parameter bit                         ROM_USE_INIT   = 1'b0,
  parameter logic [ROM_DEPTH-1:0][15:0] ROM_INIT       = '1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_tx_ready,
  output logic       o_tx_start,
  output logic [7:0] o_tx_address,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam logic [31:0] DELAY_PRODUCT = DELAY_MS * CLK_FREQUENCY / 32'd1000;
  localparam int unsigned DELAY_CYCLES  = (DELAY_PRODUCT == 32'd0) ? 32'd1 : DELAY_PRODUCT;
  localparam int unsigned CNT_W         = $clog2(DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam int unsigned IDX_W         = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d, data_q, data_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             tx_start;
  entry_t           rom_entry;

`ifdef SCCB_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  camera_config_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .USE_INIT  (ROM_USE_INIT),
    .ROM_INIT  (ROM_INIT)
  ) u_rom (
    .i_clk   (i_clk),
    .i_addr  (idx_q),
    .o_entry (rom_entry)
  );

  // Next-state, counters and handshake decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tx_start = 1'b0;
`ifdef SCCB_SEQ_TIMEOUT_EN
    wd_d     = '0;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StPowerupWait;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef SCCB_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      StPowerupWait: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (rom_entry == END_MARKER) begin
          state_d = StDone;
        end else if (rom_entry == DELAY_MARKER) begin
          cnt_d   = '0;
          state_d = StDelay;
        end else begin
          addr_d  = rom_entry.addr;
          data_d  = rom_entry.data;
          state_d = StSend;
        end
      end
      StSend: begin
        if (i_tx_ready) begin
          tx_start = 1'b1;
          state_d  = StWaitAccept;
        end
      end
      StWaitAccept: begin
        if (!i_tx_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (i_tx_ready) begin
          // The final table slot ends the pass even without an end marker.
          if (idx_q == LAST_IDX) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDelay: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef SCCB_SEQ_TIMEOUT_EN
    // Watchdog spans accept plus completion of a single write.
    if (state_q == StWaitAccept || state_q == StWaitDone) begin
      if (wd_q == WD_LAST) begin
        err_d   = 1'b1;
        state_d = StDone;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SCCB_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_tx_start   = tx_start;
  assign o_tx_address = addr_q;
  assign o_tx_data    = data_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer with a simple transmitter model:
// ready falls one cycle after start and rises again 50 cycles later.
module tb_sccb_config_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start8, start4;
  logic rdy8, rdy4;
  logic tx_start8, busy8, done8, error8;
  logic tx_start4, busy4, done4, error4;
  logic [7:0] addr8, data8, addr4, data4;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  sccb_config_sequencer #(
    .CLK_FREQUENCY  (1000000),
    .DELAY_MS       (1),
    .ROM_DEPTH      (8),
    .TIMEOUT_CYCLES (100),
    .ROM_USE_INIT   (1'b1),
    .ROM_INIT       ({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                      16'hFFFF, 16'h1100, 16'hFFF0, 16'h1280})
  ) dut8 (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start8),
    .i_tx_ready   (rdy8),
    .o_tx_start   (tx_start8),
    .o_tx_address (addr8),
    .o_tx_data    (data8),
    .o_busy       (busy8),
    .o_done       (done8),
    .o_error      (error8)
  );

  sccb_config_sequencer #(
    .CLK_FREQUENCY  (1000000),
    .DELAY_MS       (1),
    .ROM_DEPTH      (4),
    .TIMEOUT_CYCLES (100),
    .ROM_USE_INIT   (1'b1),
    .ROM_INIT       ({16'h1604, 16'h1503, 16'h1402, 16'h1301})
  ) dut4 (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start4),
    .i_tx_ready   (rdy4),
    .o_tx_start   (tx_start4),
    .o_tx_address (addr4),
    .o_tx_data    (data4),
    .o_busy       (busy4),
    .o_done       (done4),
    .o_error      (error4)
  );

  // Transmitter models; hold forces ready low, hang never completes a frame.
  logic m8_busy = 1'b0, m8_hold = 1'b0, m8_hang = 1'b0;
  logic m4_busy = 1'b0;
  int   m8_cnt = 0, m4_cnt = 0;

  always @(posedge clk) begin
    if (m8_busy) begin
      if (!m8_hang) begin
        if (m8_cnt == 49) m8_busy <= 1'b0;
        m8_cnt <= m8_cnt + 1;
      end
    end else if (tx_start8) begin
      m8_busy <= 1'b1;
      m8_cnt  <= 0;
    end
  end

  always @(posedge clk) begin
    if (m4_busy) begin
      if (m4_cnt == 49) m4_busy <= 1'b0;
      m4_cnt <= m4_cnt + 1;
    end else if (tx_start4) begin
      m4_busy <= 1'b1;
      m4_cnt  <= 0;
    end
  end

  assign rdy8 = !m8_busy && !m8_hold;
  assign rdy4 = !m4_busy;

  // Write monitors: record each accepted {addr, data} and its edge number.
  logic [15:0] w8 [0:15];
  logic [15:0] w4 [0:15];
  int          t8 [0:15];
  int          n8 = 0, n4 = 0;

  always @(posedge clk) begin
    if (tx_start8 && n8 < 16) begin
      w8[n8] <= {addr8, data8};
      t8[n8] <= cyc;
      n8     <= n8 + 1;
    end
  end

  always @(posedge clk) begin
    if (tx_start4 && n4 < 16) begin
      w4[n4] <= {addr4, data4};
      n4     <= n4 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_writes8(input int n, input int budget, input string tag);
    int k = 0;
    while (n8 < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(n8 >= n), 32'd1);
  endtask

  task automatic wait_done8(input int budget, input string tag);
    int k = 0;
    while (!done8 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(done8), 32'd1);
  endtask

  task automatic wait_done4(input int budget, input string tag);
    int k = 0;
    while (!done4 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(done4), 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    start8 = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy8),     32'd0);
    check("rst_done",  32'(done8),     32'd0);
    check("rst_error", 32'(error8),    32'd0);
    check("rst_start", 32'(tx_start8), 32'd0);
    check("rst_addr",  32'(addr8),     32'd0);
    check("rst_data",  32'(data8),     32'd0);
    rst = 1'b0;

    // Pass 1 with ready held low past the power-up wait.
    m8_hold = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("busy_after_start", 32'(busy8), 32'd1);
    check("done_after_start", 32'(done8), 32'd0);
    repeat (1300) @(negedge clk);
    check("no_start_while_not_ready", 32'(n8), 32'd0);
    check("addr_latched_in_send", 32'(addr8), 32'h12);
    m8_hold = 1'b0;
    wait_writes8(1, 10, "first_pulse_seen");
    repeat (20) @(negedge clk);
    check("single_pulse", 32'(n8), 32'd1);
    check("write0", 32'(w8[0]), 32'h1280);

    // Start during WAIT_DONE must be ignored.
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("busy_ignores_start", 32'(busy8), 32'd1);
    wait_done8(3000, "done_pass1");
    check("writes_pass1", 32'(n8), 32'd2);
    check("write1", 32'(w8[1]), 32'h1100);
    check("delay_gap", 32'(t8[1] - t8[0]), 32'd1056);
    check("busy_pass1_end", 32'(busy8), 32'd0);
    check("addr_hold", 32'({addr8, data8}), 32'h1100);

    // Restart clears done; reset in WAIT_DONE aborts; replay from entry 0.
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("done_cleared_restart", 32'(done8), 32'd0);
    check("busy_restart", 32'(busy8), 32'd1);
    wait_writes8(3, 1200, "pass2_first_write");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",  32'(busy8),     32'd0);
    check("midrst_done",  32'(done8),     32'd0);
    check("midrst_start", 32'(tx_start8), 32'd0);
    check("midrst_addr",  32'(addr8),     32'd0);
    check("midrst_data",  32'(data8),     32'd0);
    rst = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(3000, "done_after_reset");
    check("writes_after_reset", 32'(n8), 32'd5);
    check("replay_write0", 32'(w8[3]), 32'h1280);
    check("replay_write1", 32'(w8[4]), 32'h1100);

    // Table without end marker: every slot written, then done.
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4(5000, "done_no_marker");
    check("writes_no_marker", 32'(n4), 32'd4);
    check("nm_write0", 32'(w4[0]), 32'h1301);
    check("nm_write3", 32'(w4[3]), 32'h1604);
    check("nm_busy", 32'(busy4), 32'd0);

`ifdef SCCB_SEQ_TIMEOUT_EN
    begin
      int k;
      m8_hang = 1'b1;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_writes8(6, 1200, "timeout_write_issued");
      k = 0;
      while (!error8 && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("timeout_error", 32'(error8), 32'd1);
      check("timeout_cycle", 32'(cyc - t8[5]), 32'd101);
      @(negedge clk);
      check("timeout_done", 32'(done8), 32'd1);
      check("timeout_busy", 32'(busy8), 32'd0);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      check("error_cleared", 32'(error8), 32'd0);
    end
`else
    check("error_tied_low8", 32'(error8), 32'd0);
    check("error_tied_low4", 32'(error4), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
